mem_map_ctrl: RTL and testbench
===============================

Name: mem_map_ctrl

Overview:
- Parametrised memory-mapped data-side controller for the terminal CPU. Decodes one word address into three regions:
  - main RAM;
  - display (character) RAM, with an independent VGA read port;
  - a UART receive block holding a buffered RX FIFO and a status register.
- Replaces the fixed-width decoder. Full address width throughout, a registered read path with a valid strobe, and no byte loss between CPU polls.

Parameters:
- ADDR_W, 16, word-address width of addr and dbg_addr.
- MAIN_DEPTH, 256, main RAM words, mapped at 0 .. MAIN_DEPTH-1.
- DISP_BASE, 256, first display RAM word address.
- DISP_DEPTH, 4096, display RAM words; VGA port width is clog2(DISP_DEPTH).
- UART_BASE, 4352 (0x1100), UART data register. UART_BASE+1 is the status register.
- FIFO_DEPTH, 16, RX FIFO entries. Must be a power of two, 2..256.
- IRQ_THRESH, 1, FIFO count at which irq asserts (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- we  in  1  CPU write strobe
- re  in  1  CPU read strobe
- addr  in  ADDR_W  CPU word address for read/write
- wdata  in  32  CPU write data
- rdata  out  32  CPU read data
- rvalid  out  1  rdata valid, one cycle
- dbg_addr  in  ADDR_W  debug read address, main RAM only
- dbg_data  out  32  debug read data
- vga_addr  in  clog2(DISP_DEPTH)  VGA read index, relative to DISP_BASE
- vga_data  out  32  display word for VGA, character in [7:0]
- rx_byte  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe qualifying rx_byte
- irq  out  1  RX interrupt

Behaviour:
- Decode uses the full ADDR_W-bit addr:
  - main: addr < MAIN_DEPTH;
  - disp: DISP_BASE <= addr < DISP_BASE+DISP_DEPTH;
  - udata: addr == UART_BASE;
  - ustat: addr == UART_BASE+1;
  - anything else is unmapped.
- Writes:
  - complete in the cycle we=1;
  - main and disp store wdata at the region offset;
  - ustat: wdata[2]=1 clears the overflow flag;
  - udata writes and unmapped writes are ignored.
- Reads:
  - re sampled at a rising edge; rdata/rvalid valid on the following edge (latency 1);
  - rvalid is high for exactly one cycle per re;
  - rdata holds its value until the next read.
- Read data per region:
  - main/disp: the stored word;
  - unmapped: 0x0000_0000.
- udata read:
  - FIFO non-empty: returns {23'b0, 1'b1, head byte} and pops the head;
  - FIFO empty: returns 0x0000_0000, no pop.
- ustat read returns:
  - bit0 = not-empty, bit1 = full, bit2 = overflow (sticky);
  - [15:8] = count;
  - all other bits 0.
- If we and re are high together on the same address, the read returns the old data.
- Push: on rx_valid, rx_byte is written at the tail.
  - Full FIFO: the byte is dropped and overflow is set.
  - An overflow set and a ustat clear in the same cycle: set wins.
- Simultaneous push and pop:
  - non-empty FIFO: both happen, count unchanged;
  - empty FIFO: push only, and the read returns the empty value.
  - This also applies when the FIFO is full, so a pop in the same cycle makes room and no overflow occurs.
- Pointers are clog2(FIFO_DEPTH) bits and wrap naturally. Count is clog2(FIFO_DEPTH)+1 bits.
- dbg_data: registered main RAM read at dbg_addr, latency 1, free-running. dbg_addr outside main returns 0.
- vga_data: registered display RAM read, latency 1, free-running, independent of CPU traffic.
- Reset clears:
  - rdata = 0, rvalid = 0, dbg_data = 0, vga_data = 0, irq = 0;
  - FIFO pointers and count = 0, overflow = 0.
  - A mid-operation reset flushes the FIFO, and a pending read yields no rvalid.
  - RAM contents are not reset.

Optional Feature:
- Macro: MEMCTRL_RX_IRQ_EN.
- Defined:
  - irq is registered and high while count >= IRQ_THRESH or overflow = 1;
  - it falls the cycle after the condition clears;
  - ustat bit3 reads 1 when irq is high.
- Not defined:
  - irq is tied to 0, ustat bit3 reads 0, IRQ_THRESH is unused.

Test Plan:
- Write 0xA5A5_0001 to addr 5, then read addr 5 -> rvalid one cycle later, rdata = 0xA5A5_0001; dbg_addr=5 gives dbg_data = 0xA5A5_0001.
- Write 0x0000_0041 to addr 256+80 -> vga_addr=80 gives vga_data = 0x41 one cycle later. A read of addr 0x2000 returns 0 and a write there changes nothing.
- Push bytes 0x31, 0x32, 0x33 -> ustat = 0x0000_0301. Three udata reads return 0x131, 0x132, 0x133. A fourth read returns 0 and ustat = 0.
- Push 17 bytes with default depth -> ustat = 0x0000_1007 and the 17th byte is lost. Writing 0x4 to ustat -> ustat = 0x0000_1003.
- Fill to full, then pulse rx_valid together with a udata read -> no overflow, count stays 16, and the read returns the oldest byte.
- With MEMCTRL_RX_IRQ_EN and IRQ_THRESH=2: after 1 push irq=0, after 2 pushes irq=1, after 1 pop irq=0. Assert rst mid-stream -> count 0, irq 0, rvalid 0.

Source files
------------

// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: CPU data-side decoder for main RAM, display RAM and UART RX FIFO; optional MEMCTRL_RX_IRQ_EN
module mem_map_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int MAIN_DEPTH = 256,
  parameter int DISP_BASE  = 256,
  parameter int DISP_DEPTH = 4096,
  parameter int UART_BASE  = 4352,
  parameter int FIFO_DEPTH = 16,
  parameter int IRQ_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          rvalid,
  input  logic [ADDR_W-1:0]             dbg_addr,
  output logic [31:0]                   dbg_data,
  input  logic [$clog2(DISP_DEPTH)-1:0] vga_addr,
  output logic [31:0]                   vga_data,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  output logic                          irq
);
  localparam int MW = $clog2(MAIN_DEPTH);
  localparam int DW = $clog2(DISP_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      IRQ_THRESH < 0 || IRQ_THRESH > FIFO_DEPTH) begin : g_bad_params
    $error("mem_map_ctrl: FIFO_DEPTH must be a power of two in 2..256 and IRQ_THRESH within 0..FIFO_DEPTH");
  end
  logic [31:0] main_mem [MAIN_DEPTH];
  logic [31:0] disp_mem [DISP_DEPTH];
  logic [7:0]  fifo [FIFO_DEPTH];
  logic [31:0] a32, rd_next, stat;
  logic [DW-1:0] doff;
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic is_main, is_disp, is_udata, is_ustat, ne, full, pop, push, ovf, ovf_set, ovf_clr;
  // Address decode, FIFO handshakes and read-data selection
  always_comb begin
    a32      = 32'(addr);
    doff     = DW'(a32 - 32'(DISP_BASE));
    is_main  = a32 < 32'(MAIN_DEPTH);
    is_disp  = a32 >= 32'(DISP_BASE) && a32 < 32'(DISP_BASE + DISP_DEPTH);
    is_udata = a32 == 32'(UART_BASE);
    is_ustat = a32 == 32'(UART_BASE + 1);
    ne       = count != '0;
    full     = count == FULL;
    pop      = re && is_udata && ne;
    push     = rx_valid && (!full || pop);
    ovf_set  = rx_valid && full && !pop;
    ovf_clr  = we && is_ustat && wdata[2];
    stat     = {16'b0, 8'(count), 4'b0, irq, ovf, full, ne};
    rd_next  = is_main  ? main_mem[addr[MW-1:0]] :
               is_disp  ? disp_mem[doff] :
               is_udata ? (ne ? {23'b0, 1'b1, fifo[rp]} : 32'b0) :
               is_ustat ? stat : 32'b0;
  end
  // RAM and FIFO storage, never reset
  always_ff @(posedge clk) begin
    if (we && is_main) main_mem[addr[MW-1:0]] <= wdata;
    if (we && is_disp) disp_mem[doff] <= wdata;
    if (push) fifo[wp] <= rx_byte;
  end
  // Registered read ports, FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      dbg_data <= '0;
      vga_data <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      rvalid   <= re;
      rdata    <= re ? rd_next : rdata;
      dbg_data <= 32'(dbg_addr) < 32'(MAIN_DEPTH) ? main_mem[dbg_addr[MW-1:0]] : '0;
      vga_data <= disp_mem[vga_addr];
      wp       <= push ? wp + 1'b1 : wp;
      rp       <= pop ? rp + 1'b1 : rp;
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      ovf      <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
    end
  end
`ifdef MEMCTRL_RX_IRQ_EN
  // Interrupt follows the FIFO level or overflow one cycle late
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else irq <= count >= (PW+1)'(IRQ_THRESH) || ovf;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mem_map_ctrl.sv
// tb_mem_map_ctrl: scoreboard bench for mem_map_ctrl
module tb_mem_map_ctrl;
  logic clk = 0, rst = 1, we = 0, re = 0, rx_valid = 0;
  logic [15:0] addr = 0, dbg_addr = 0;
  logic [11:0] vga_addr = 0;
  logic [31:0] wdata = 0, rdata, dbg_data, vga_data;
  logic [7:0] rx_byte = 0;
  logic rvalid, irq;
  int tests = 0, fails = 0;
  logic [31:0] exp_q [$];
  string name_q [$];
`ifdef MEMCTRL_RX_IRQ_EN
  localparam logic [31:0] IB = 32'h8;
`else
  localparam logic [31:0] IB = 32'h0;
`endif
  localparam logic [15:0] UD = 16'h1100, US = 16'h1101;
  mem_map_ctrl #(.IRQ_THRESH(2)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .vga_addr(vga_addr), .vga_data(vga_data), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: rdata=%h, no read outstanding", rdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("FAIL %s: rdata=%h expected %h", n, rdata, e);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] e);
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    cyc();
    we = 0;
  endtask
  task automatic rd(input string n, input logic [15:0] a, input logic [31:0] e);
    re = 1; addr = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    cyc();
    re = 0;
  endtask
  task automatic push(input logic [7:0] b);
    rx_valid = 1; rx_byte = b;
    cyc();
    rx_valid = 0;
  endtask
  initial begin
    cyc(); cyc();
    check("reset_rdata", rdata, 0);
    check("reset_rvalid", {31'b0, rvalid}, 0);
    check("reset_dbg", dbg_data, 0);
    check("reset_vga", vga_data, 0);
    check("reset_irq", {31'b0, irq}, 0);
    rst = 0;
    cyc();
    wr(5, 32'hA5A5_0001);
    rd("main_rd", 5, 32'hA5A5_0001);
    dbg_addr = 5;
    cyc();
    check("dbg_rd", dbg_data, 32'hA5A5_0001);
    dbg_addr = 16'h0100;
    cyc();
    check("dbg_outside", dbg_data, 0);
    wr(256 + 80, 32'h41);
    vga_addr = 80;
    cyc();
    check("vga_rd", vga_data, 32'h41);
    rd("disp_cpu_rd", 256 + 80, 32'h41);
    wr(255, 32'h1234_5678);
    rd("main_top", 255, 32'h1234_5678);
    wr(16'h10FF, 32'hCAFE_F00D);
    rd("disp_top", 16'h10FF, 32'hCAFE_F00D);
    vga_addr = 12'hFFF;
    cyc();
    check("vga_top", vga_data, 32'hCAFE_F00D);
    rd("unmapped_rd", 16'h2000, 0);
    wr(16'h2000, 32'hDEAD_BEEF);
    rd("unmapped_after_wr", 16'h2000, 0);
    we = 1; re = 1; addr = 5; wdata = 32'h0BAD_0005;
    exp_q.push_back(32'hA5A5_0001); name_q.push_back("rw_same_old");
    cyc();
    we = 0; re = 0;
    rd("rw_same_new", 5, 32'h0BAD_0005);
    push(8'h31); push(8'h32); push(8'h33);
    rd("stat_3", US, 32'h301 | IB);
    rd("pop_31", UD, 32'h131);
    rd("pop_32", UD, 32'h132);
    rd("pop_33", UD, 32'h133);
    rd("pop_empty", UD, 0);
    rd("stat_empty", US, 0);
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    rd("stat_ovf", US, 32'h1007 | IB);
    wr(US, 32'h4);
    rd("stat_ovf_clr", US, 32'h1003 | IB);
    rx_valid = 1; rx_byte = 8'h99; re = 1; addr = UD;
    exp_q.push_back(32'h140); name_q.push_back("full_push_pop");
    cyc();
    rx_valid = 0; re = 0;
    rd("stat_full_no_ovf", US, 32'h1003 | IB);
    for (int i = 1; i < 16; i++) rd($sformatf("drain_%0d", i), UD, 32'h140 + 32'(i));
    rd("drain_99", UD, 32'h199);
    rd("drain_empty", UD, 0);
    rx_valid = 1; rx_byte = 8'h77; re = 1; addr = UD;
    exp_q.push_back(0); name_q.push_back("empty_push_pop");
    cyc();
    rx_valid = 0; re = 0;
    rd("stat_one", US, 32'h101);
    rd("pop_77", UD, 32'h177);
`ifdef MEMCTRL_RX_IRQ_EN
    push(8'h01);
    cyc();
    check("irq_1push", {31'b0, irq}, 0);
    push(8'h02);
    cyc();
    check("irq_2push", {31'b0, irq}, 1);
    rd("irq_pop", UD, 32'h101);
    cyc();
    check("irq_after_pop", {31'b0, irq}, 0);
    rd("irq_pop2", UD, 32'h102);
`endif
    push(8'h51); push(8'h52); push(8'h53);
    rst = 1; re = 1; addr = UD;
    cyc();
    rst = 0; re = 0;
    check("midrst_rvalid", {31'b0, rvalid}, 0);
    cyc();
    check("midrst_rvalid2", {31'b0, rvalid}, 0);
    check("midrst_irq", {31'b0, irq}, 0);
    rd("midrst_stat", US, 0);
    rd("midrst_udata", UD, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
